// File: rtl/rgb2raw.sv
// Bayer re-mosaicer: samples one colour per RGB pixel according to PATTERN and
// packs IN_PCNT-pixel beats into OUT_PCNT-pixel raw words, flushing partial words at line end.
module rgb2raw #(
  parameter int          PW       = 8,
  parameter int          IN_PCNT  = 2,
  parameter int          OUT_PCNT = 4,
  parameter int          MAX_HRES = 3840,
  parameter int          MAX_VRES = 2160,
  parameter logic [31:0] PATTERN  = "GBRG"
) (
  input  logic                        i_pclk,
  input  logic                        i_rstn,
  input  logic                        i_vsync,
  input  logic                        i_hsync,
  input  logic                        i_de,
  input  logic                        i_valid,
  input  logic [PW*IN_PCNT-1:0]       i_r,
  input  logic [PW*IN_PCNT-1:0]       i_g,
  input  logic [PW*IN_PCNT-1:0]       i_b,
  output logic                        o_vsync,
  output logic                        o_hsync,
  output logic                        o_de,
  output logic                        o_valid,
  output logic [$clog2(MAX_HRES)-1:0] o_x_cnt,
  output logic [$clog2(MAX_VRES)-1:0] o_y_cnt,
  output logic [PW*OUT_PCNT-1:0]      o_raw
);
  localparam int R   = OUT_PCNT / IN_PCNT;
  localparam int XW  = $clog2(MAX_HRES);
  localparam int YW  = $clog2(MAX_VRES);
  localparam int BW  = PW * IN_PCNT;
  localparam int OW  = PW * OUT_PCNT;
  localparam int PHW = (R > 1) ? $clog2(R) : 1;
  localparam logic [PHW-1:0] PH_LAST = PHW'(R - 1);

  if (!((OUT_PCNT == IN_PCNT) || (OUT_PCNT == 2 * IN_PCNT) || (OUT_PCNT == 4 * IN_PCNT)))
  begin : g_bad_ratio
    $error("rgb2raw: OUT_PCNT/IN_PCNT must be 1, 2 or 4");
  end
  if (PATTERN != "RGGB" && PATTERN != "GRBG" && PATTERN != "GBRG" && PATTERN != "BGGR")
  begin : g_bad_pattern
    $error("rgb2raw: unsupported PATTERN");
  end

  typedef enum logic [1:0] {C_R, C_G, C_B} colour_e;

  // PATTERN characters read left to right: (even,even) (even,odd) (odd,even) (odd,odd)
  function automatic colour_e cfa_colour(input logic row, input logic col);
    logic [7:0] ch;
    case ({row, col})
      2'b00:   ch = PATTERN[31:24];
      2'b01:   ch = PATTERN[23:16];
      2'b10:   ch = PATTERN[15:8];
      default: ch = PATTERN[7:0];
    endcase
    if (ch == "R")      return C_R;
    else if (ch == "G") return C_G;
    else                return C_B;
  endfunction

  logic           vs_d1_q, vs_d2_q, hs_d1_q, hs_d2_q, de_d1_q, de_d2_q;
  logic [XW-1:0]  x_q, x_d, x0_q, x0_d, wx_q, wx_d, ox_q, ox_d;
  logic [YW-1:0]  y_q, y_d, y0_q, y0_d, wy_q, wy_d, oy_q, oy_d;
  logic [PHW-1:0] ph_q, ph_d;
  logic [OW-1:0]  acc_q, acc_d, word_q, word_d, oraw_q, oraw_d, fill;
  logic           wv_q, wv_d, ov_q, ov_d;
  logic [BW-1:0]  beat_data;
  logic           vs_rise, de_fall, beat;

  always_comb begin
    beat_data = '0;
    for (int unsigned k = 0; k < IN_PCNT; k++) begin
      case (cfa_colour(y_q[0], x_q[0] ^ k[0]))
        C_R:     beat_data[k*PW +: PW] = i_r[k*PW +: PW];
        C_G:     beat_data[k*PW +: PW] = i_g[k*PW +: PW];
        default: beat_data[k*PW +: PW] = i_b[k*PW +: PW];
      endcase
    end
  end

  always_comb begin
    vs_rise = i_vsync & ~vs_d1_q;
    de_fall = ~i_de & de_d1_q;
    beat    = i_de & i_valid;
    x_d = x_q;  y_d = y_q;  x0_d = x0_q;  y0_d = y0_q;
    ph_d = ph_q;  acc_d = acc_q;
    wv_d = 1'b0;  word_d = word_q;  wx_d = wx_q;  wy_d = wy_q;
    ov_d = 1'b0;  oraw_d = oraw_q;  ox_d = ox_q;  oy_d = oy_q;

    fill = acc_q;
    for (int unsigned s = 0; s < R; s++) begin
      if (ph_q == PHW'(s)) fill[s*BW +: BW] = beat_data;
    end

    if (wv_q) begin
      ov_d = 1'b1;  oraw_d = word_q;  ox_d = wx_q;  oy_d = wy_q;
    end

    if (vs_rise) begin
      x_d = '0;  y_d = '0;  ph_d = '0;  acc_d = '0;
    end else if (de_fall) begin
      x_d = '0;
      if (32'(y_q) + 32'd1 >= 32'(MAX_VRES - 1)) y_d = YW'(MAX_VRES - 1);
      else                                     y_d = y_q + YW'(1);
      // Flush skips the word stage so it lands on the last delayed-de cycle;
      // the accumulator already holds zeros in unfilled slots.
      if (ph_q != '0) begin
        ov_d = 1'b1;  oraw_d = acc_q;  ox_d = x0_q;  oy_d = y0_q;
      end
      ph_d = '0;  acc_d = '0;
    end else if (beat) begin
      if (32'(x_q) + 32'(IN_PCNT) >= 32'(MAX_HRES - 1)) x_d = XW'(MAX_HRES - 1);
      else                                            x_d = x_q + XW'(IN_PCNT);
      if (ph_q == '0) begin
        x0_d = x_q;  y0_d = y_q;
      end
      if (ph_q == PH_LAST) begin
        wv_d   = 1'b1;
        word_d = fill;
        wx_d   = (ph_q == '0) ? x_q : x0_q;
        wy_d   = (ph_q == '0) ? y_q : y0_q;
        acc_d  = '0;
        ph_d   = '0;
      end else begin
        acc_d = fill;
        ph_d  = ph_q + PHW'(1);
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_d1_q <= 1'b0;  vs_d2_q <= 1'b0;
      hs_d1_q <= 1'b0;  hs_d2_q <= 1'b0;
      de_d1_q <= 1'b0;  de_d2_q <= 1'b0;
      x_q <= '0;  y_q <= '0;  x0_q <= '0;  y0_q <= '0;
      ph_q <= '0;  acc_q <= '0;
      wv_q <= 1'b0;  word_q <= '0;  wx_q <= '0;  wy_q <= '0;
      ov_q <= 1'b0;  oraw_q <= '0;  ox_q <= '0;  oy_q <= '0;
    end else begin
      vs_d1_q <= i_vsync;  vs_d2_q <= vs_d1_q;
      hs_d1_q <= i_hsync;  hs_d2_q <= hs_d1_q;
      de_d1_q <= i_de;     de_d2_q <= de_d1_q;
      x_q <= x_d;  y_q <= y_d;  x0_q <= x0_d;  y0_q <= y0_d;
      ph_q <= ph_d;  acc_q <= acc_d;
      wv_q <= wv_d;  word_q <= word_d;  wx_q <= wx_d;  wy_q <= wy_d;
      ov_q <= ov_d;  oraw_q <= oraw_d;  ox_q <= ox_d;  oy_q <= oy_d;
    end
  end

  assign o_vsync = vs_d2_q;
  assign o_hsync = hs_d2_q;
  assign o_de    = de_d2_q;
  assign o_valid = ov_q;
  assign o_raw   = oraw_q;
  assign o_x_cnt = ox_q;
  assign o_y_cnt = oy_q;
endmodule

// File: tb/tb_rgb2raw.sv
// Randomized bench for rgb2raw: four instances (one per Bayer pattern) share the stimulus
// and are checked against a pixel-level reference model of colour sampling and packing.
module tb_rgb2raw;
  localparam int PW = 8, IP = 2, OP = 4, NI = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic vs = 1'b0, hs = 1'b0, de = 1'b0, valid = 1'b0;
  logic [PW*IP-1:0] r = '0, g = '0, b = '0;
  logic             ov [NI];
  logic             ovs [NI];
  logic             ohs [NI];
  logic             ode [NI];
  logic [PW*OP-1:0] oraw [NI];
  logic [11:0]      ox [NI];
  logic [11:0]      oy [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    rgb2raw #(
      .PW(PW), .IN_PCNT(IP), .OUT_PCNT(OP), .MAX_HRES(3840), .MAX_VRES(2160),
      .PATTERN(gi == 0 ? "GBRG" : gi == 1 ? "RGGB" : gi == 2 ? "GRBG" : "BGGR")
    ) u_dut (
      .i_pclk(clk), .i_rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_valid(valid),
      .i_r(r), .i_g(g), .i_b(b),
      .o_vsync(ovs[gi]), .o_hsync(ohs[gi]), .o_de(ode[gi]), .o_valid(ov[gi]),
      .o_x_cnt(ox[gi]), .o_y_cnt(oy[gi]), .o_raw(oraw[gi])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [PW*OP-1:0] raw; int x; int y; int cyc; } wexp_t;
  wexp_t      expq [NI][$];
  logic [7:0] pend [NI][$];
  string      pats [NI] = '{"GBRG", "RGGB", "GRBG", "BGGR"};
  int         y_m = 0, pend_x = 0, te = 0;

  function automatic logic [7:0] pick(input int inst, input int row, input int col,
                                      input logic [7:0] rv, input logic [7:0] gv,
                                      input logic [7:0] bv);
    string s;
    byte   c;
    s = pats[inst];
    c = s[(row % 2) * 2 + (col % 2)];
    if (c == "R") return rv;
    if (c == "G") return gv;
    return bv;
  endfunction

  function automatic logic [PW*OP-1:0] pack(input int inst);
    logic [PW*OP-1:0] w = '0;
    for (int j = 0; j < pend[inst].size(); j++) w[j*PW +: PW] = pend[inst][j];
    return w;
  endfunction

  task automatic model_beat(input int xpos);
    wexp_t w;
    if (pend[0].size() == 0) pend_x = xpos;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < IP; k++)
        pend[i].push_back(pick(i, y_m, xpos + k, r[k*PW +: PW], g[k*PW +: PW], b[k*PW +: PW]));
      if (pend[i].size() == OP) begin
        w.raw = pack(i); w.x = pend_x; w.y = y_m; w.cyc = cyc + 2;
        expq[i].push_back(w);
        pend[i].delete();
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      pend[i].delete();
      expq[i].delete();
    end
    y_m = 0;
  endtask

  // ---------------- monitor ----------------
  logic [2:0] h1 = '0, h2 = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      h1 = '0; h2 = '0;
    end else begin
      chk("sync_delay", {ovs[0], ohs[0], ode[0]}, h2);
      h2 = h1;
      h1 = {vs, hs, de};
      for (int i = 0; i < NI; i++) begin
        if (ov[i]) begin
          chk($sformatf("word_expected[%0d]", i), expq[i].size() != 0, 1);
          if (expq[i].size() != 0) begin
            wexp_t w;
            w = expq[i].pop_front();
            chk($sformatf("raw[%0d]", i), oraw[i], w.raw);
            chk($sformatf("x_cnt[%0d]", i), ox[i], w.x);
            chk($sformatf("y_cnt[%0d]", i), oy[i], w.y);
            chk($sformatf("valid_cycle[%0d]", i), cyc, w.cyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input bit fixed);
    if (fixed) begin
      r = {IP{8'h11}}; g = {IP{8'h22}}; b = {IP{8'h33}};
    end else begin
      r = PW*IP'($urandom); g = PW*IP'($urandom); b = PW*IP'($urandom);
    end
  endtask

  task automatic vsync_pulse();
    tick(); vs = 1'b1; de = 1'b0; valid = 1'b0;
    model_clear();
    tick();
    tick(); vs = 1'b0;
    repeat (2) tick();
  endtask

  // gapmode: 0 none, 1 one idle cycle between beats, 2 random idle cycles
  task automatic run_line(input int npix, input int gapmode, input bit fixed);
    wexp_t w;
    int xp = 0;
    for (int bi = 0; bi < npix / IP; bi++) begin
      if (bi > 0 && (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 1) == 1))) begin
        tick(); de = 1'b1; valid = 1'b0; set_pix(1'b0);
      end
      tick(); de = 1'b1; valid = 1'b1; set_pix(fixed);
      model_beat(xp);
      xp += IP;
      te = cyc;
    end
    tick(); de = 1'b0; valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (pend[i].size() != 0) begin
        w.raw = pack(i); w.x = pend_x; w.y = y_m; w.cyc = te + 2;
        expq[i].push_back(w);
        pend[i].delete();
      end
    end
    y_m++;
    tick(); hs = 1'b1;
    tick(); hs = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_valid"}, ov[i], 0);
      chk({tag, "_raw"}, oraw[i], 0);
      chk({tag, "_xy"}, {ox[i], oy[i]}, 0);
      chk({tag, "_sync"}, {ovs[i], ohs[i], ode[i]}, 0);
    end
  endtask

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    vsync_pulse();

    // constant colours, full words
    run_line(8, 0, 1'b1);
    run_line(8, 0, 1'b1);
    // 6-pixel lines: second word of each line is a flush
    vsync_pulse();
    run_line(6, 0, 1'b1);
    run_line(6, 0, 1'b1);
    // valid gaps between every beat
    vsync_pulse();
    run_line(8, 1, 1'b1);
    run_line(8, 1, 1'b1);
    // random lengths, gaps and colours
    vsync_pulse();
    for (int l = 0; l < 8; l++) run_line(2 * $urandom_range(1, 10), 2, 1'b0);

    // vsync rises together with the de fall after a partial word: nothing emitted
    tick(); de = 1'b1; valid = 1'b1; set_pix(1'b0);
    tick(); de = 1'b0; valid = 1'b0; vs = 1'b1;
    model_clear();
    tick();
    tick(); vs = 1'b0;
    repeat (2) tick();
    run_line(8, 0, 1'b0);
    run_line(6, 0, 1'b0);

    // vsync rises on the completing beat: that word is discarded
    vsync_pulse();
    tick(); de = 1'b1; valid = 1'b1; set_pix(1'b0);
    tick(); de = 1'b1; valid = 1'b1; vs = 1'b1; set_pix(1'b0);
    model_clear();
    tick(); de = 1'b0; valid = 1'b0;
    y_m++;
    tick(); vs = 1'b0;
    repeat (2) tick();
    vsync_pulse();
    run_line(8, 2, 1'b0);

    // reset mid-line
    vsync_pulse();
    for (int bi = 0; bi < 3; bi++) begin
      tick(); de = 1'b1; valid = 1'b1; set_pix(1'b0);
      model_beat(bi * IP);
    end
    tick(); rstn = 1'b0; de = 1'b0; valid = 1'b0;
    model_clear();
    #1;
    check_all_zero("midline_reset");
    repeat (3) tick();
    rstn = 1'b1;
    vsync_pulse();
    run_line(8, 0, 1'b0);
    run_line(6, 2, 1'b0);

    repeat (5) tick();
    for (int i = 0; i < NI; i++) chk($sformatf("leftover[%0d]", i), expq[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rgb2raw.md
# rgb2raw

Bayer re-mosaicer, the inverse direction of `raw2rgb`. It accepts a parallel-pixel RGB video stream (`i_r`/`i_g`/`i_b` planes plus sync/de/valid), samples one colour per pixel according to the Bayer `PATTERN`, and packs the samples into a wider raw stream. Its output has the same format that `raw2rgb` consumes, so a `raw2rgb` → `rgb2raw` loop can round-trip a sensor stream. It sits between the ISP output and any raw-domain consumer (raw encoder, loopback test, sensor emulator).

## Interface
- `PW`, 8, bits per colour sample.
- `IN_PCNT`, 2, RGB pixels per input beat.
- `OUT_PCNT`, 4, raw pixels per output word. `R = OUT_PCNT/IN_PCNT` must be 1, 2 or 4; any other value is an elaboration error.
- `MAX_HRES`, 3840, maximum active width.
- `MAX_VRES`, 2160, maximum active height.
- `PATTERN`, "GBRG", one of "RGGB", "GRBG", "GBRG", "BGGR". Any other value is an elaboration error.
- `i_pclk`  in  1  pixel clock; the only clock.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_vsync`, `i_hsync`, `i_de`  in  1 each  input timing.
- `i_valid`  in  1  input beat qualifier, meaningful only while `i_de`=1.
- `i_r`, `i_g`, `i_b`  in  PW*IN_PCNT each  colour planes; pixel k is in bits [k*PW +: PW].
- `o_vsync`, `o_hsync`, `o_de`  out  1 each  timing, delayed 2 cycles.
- `o_valid`  out  1  `o_raw` qualifier.
- `o_x_cnt`  out  $clog2(MAX_HRES)  x of lane 0 of `o_raw`.
- `o_y_cnt`  out  $clog2(MAX_VRES)  line index of `o_raw`.
- `o_raw`  out  PW*OUT_PCNT  raw word; lane 0 is in the LSBs.

## Operation
- Counters:
  - `y` clears on the `i_vsync` rising edge and increments on each `i_de` falling edge.
  - `x` clears on the `i_de` falling edge and on the `i_vsync` rising edge, and advances by `IN_PCNT` per valid beat.
- Colour select for input lane k: row parity `y[0]`, column parity `(x+k)[0]`.
  - RGGB: even row R,G; odd row G,B.
  - GRBG: even row G,R; odd row B,G.
  - GBRG: even row G,B; odd row R,G.
  - BGGR: even row B,G; odd row G,R.
- Packer:
  - Phase counter `ph` runs 0..R-1. Each valid beat writes its IN_PCNT samples to slot `ph` of the accumulator, then increments `ph`.
  - The beat with `ph`=R-1 completes a word; `ph` returns to 0.
  - Gaps in `i_valid` while `i_de`=1 hold `ph` and the accumulator.
- Line-end flush:
  - Condition: `i_de` falling edge (`i_de`=0 and previous `i_de`=1) with `ph`≠0.
  - Action: emit the partial word with unfilled slots zeroed, then clear `ph`.
- `i_vsync` rising edge clears `ph` and the accumulator, discarding any partial word with no output. It also clears `y`.
- `o_x_cnt`/`o_y_cnt` are the `x`/`y` of the first beat packed into the emitted word.

## Timing
- Reset (async assert, sync deassert handled externally): every output is 0. `ph`, `x`, `y` and the delay lines are 0.
- Sync path: `o_vsync`/`o_hsync`/`o_de` equal the corresponding input delayed 2 cycles.
- Completed word: the beat completing it at cycle c gives `o_valid`=1 at c+2 (two register stages).
- Flush word: with last `i_de`=1 cycle te, the fall is detected at te+1 and the word shows `o_valid`=1 at te+2, the last cycle of `o_de`=1. It cannot collide with a normal word, because the last normal completion is ≤ te-1, so it is visible ≤ te+1.
- All words fall inside the delayed `o_de` window. `o_valid` is a single-cycle pulse per word.
- `i_vsync` rising in the same cycle as a completing beat: the beat is discarded with no output, and `x`, `y`, `ph` are cleared.
- `x` saturates at MAX_HRES-1 and `y` at MAX_VRES-1 for non-conforming input; neither wraps.

## Test plan
- GBRG, IN_PCNT=2, OUT_PCNT=4, 8-pixel lines, constant r=0x11, g=0x22, b=0x33 → line 0 words 0x33223322, line 1 words 0x22112211; `o_x_cnt` 0,4; `o_valid` 2 cycles after the 2nd/4th beat.
- Same setup, 6-pixel lines → 2nd word of line 0 = 0x00003322 (flush), `o_valid` exactly at te+2, `o_x_cnt`=4.
- Valid gaps: 1-cycle `i_valid`=0 between every beat of an 8-pixel line → words identical to scenario 1, each `o_valid` 2 cycles after its completing beat.
- Pattern sweep RGGB/GRBG/BGGR with same colours → line 0 words 0x22112211, 0x11221122, 0x22332233 respectively.
- `i_vsync` rising after 1 beat of a line → no `o_valid` for that beat; next frame starts with `y`=0, `ph`=0.
- `i_rstn` asserted mid-line → all outputs 0 immediately; after release, first word of the next frame is correct.
